// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS sequencing controller with memory handshake and retire counter
module multicycle_control_fsm #(
    parameter int COUNT_WIDTH     = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   zero,
    input  logic                   memReady,
    output logic                   memReq,
    output logic                   memWrite,
    output logic                   IorD,
    output logic                   IRWrite,
    output logic                   PCWrite,
    output logic [1:0]             PCSrc,
    output logic                   regWrite,
    output logic                   RegDst,
    output logic                   MemtoReg,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [4:0]             ALUControl,
    output logic [3:0]             state,
    output logic [COUNT_WIDTH-1:0] retired
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;
    localparam logic [3:0] S_HALT   = 4'd13;

    localparam logic [3:0] S_ILLEGAL = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_SLT = 5'b00111;

    logic [3:0]             state_q, state_d;
    logic [COUNT_WIDTH-1:0] retired_q, retired_d;
    logic                   retire;
    logic                   funct_legal;
    logic [4:0]             funct_alu;

    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = 5'b00000;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (memReady) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            // IR still holds lw or sw here, so the opcode alone picks the access type
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (memReady) state_d = S_MEMWB;
            S_MEMWR: begin
                if (memReady) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:   state_d = funct_legal ? S_ALUWB : S_ILLEGAL;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    assign retired_d = retire ? retired_q + COUNT_WIDTH'(1) : retired_q;

    always_comb begin
        memReq     = 1'b0;
        memWrite   = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 2'b00;
        regWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 5'b00000;
        case (state_q)
            S_FETCH: begin
                memReq     = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                IRWrite    = memReady;
                PCWrite    = memReady;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
            end
            S_MEMRD: begin
                memReq = 1'b1;
                IorD   = 1'b1;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                memReq   = 1'b1;
                memWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu;
            end
            S_ALUWB: begin
                regWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_ADDIWB: regWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                PCWrite    = zero;
            end
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule
